// File: rtl/playfield_engine.sv
// playfield_engine: playfield storage, piece commit, multi-row clear, BCD scoring,
// garbage-row injection from a FIFO and top-out detection.
// Ports: clk, reset_n (async, active low)
//   place_valid/place_mask/place_kind  commit request, accepted while ready
//   ready/busy/done                    handshake, done pulses once per commit
//   gq_push/gq_hole/gq_full/gq_count   garbage-row FIFO
//   clear_board                        synchronous wipe and abort
//   rd_x/rd_y -> rd_kind               registered cell read port
//   lines_last/score/topout            result and status
module playfield_engine #(
    parameter int COLS      = 10,
    parameter int ROWS      = 20,
    parameter int KW        = 3,
    parameter int GQ_DEPTH  = 8,
    parameter int GARB_KIND = 7
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      place_valid,
    input  logic [ROWS*COLS-1:0]      place_mask,
    input  logic [KW-1:0]             place_kind,
    output logic                      ready,
    output logic                      done,
    output logic                      busy,
    input  logic                      gq_push,
    input  logic [$clog2(COLS)-1:0]   gq_hole,
    output logic                      gq_full,
    output logic [$clog2(GQ_DEPTH):0] gq_count,
    input  logic                      clear_board,
    input  logic [$clog2(COLS)-1:0]   rd_x,
    input  logic [$clog2(ROWS)-1:0]   rd_y,
    output logic [KW-1:0]             rd_kind,
    output logic [$clog2(ROWS+1)-1:0] lines_last,
    output logic [15:0]               score,
    output logic                      topout
);

    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);
    localparam int QW = $clog2(GQ_DEPTH);
    localparam int LW = $clog2(ROWS+1);
    localparam int RW = COLS*KW;

    localparam logic [QW:0] CNT_ONE  = (QW+1)'(1);
    localparam logic [QW:0] CNT_FULL = (QW+1)'(GQ_DEPTH);

    typedef logic [RW-1:0] row_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MERGE,
        S_SCAN,
        S_SCORE,
        S_GARB,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    row_t                 board_q [ROWS];
    row_t                 board_d [ROWS];
    logic [ROWS*COLS-1:0] mask_q, mask_d;
    logic [KW-1:0]        kind_q, kind_d;
    logic [YW-1:0]        r_q, r_d;
    logic [LW-1:0]        k_q, k_d;
    logic [15:0]          score_q, score_d;
    logic [LW-1:0]        lines_q, lines_d;
    logic                 topout_q, topout_d;
    logic [XW-1:0]        gq_mem_q [GQ_DEPTH];
    logic [QW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [QW:0]          cnt_q, cnt_d;
    logic                 pop;
    logic                 push_ok;
    logic [KW-1:0]        rd_kind_q, rd_kind_d;
    logic [3:0]           pts;

    function automatic logic row_full(input row_t row);
        logic f;
        f = 1'b1;
        for (int x = 0; x < COLS; x++) begin
            if (row[x*KW +: KW] == '0) f = 1'b0;
        end
        return f;
    endfunction

    // A hole index at or beyond COLS matches no column, giving a full row.
    function automatic row_t garb_row(input logic [XW-1:0] hole);
        row_t row;
        row = '0;
        for (int x = 0; x < COLS; x++) begin
            row[x*KW +: KW] = (32'(hole) == x) ? '0 : KW'(GARB_KIND);
        end
        return row;
    endfunction

    // Ripple BCD add; a carry out of the top digit pins the result at 9999.
    function automatic logic [15:0] bcd_add(input logic [15:0] a,
                                            input logic [3:0]  inc);
        logic [4:0]  s;
        logic [3:0]  c;
        logic [15:0] res;
        res = '0;
        c   = inc;
        for (int d = 0; d < 4; d++) begin
            s = {1'b0, a[d*4 +: 4]} + {1'b0, c};
            if (s > 5'd9) begin
                res[d*4 +: 4] = 4'(s - 5'd10);
                c = 4'd1;
            end else begin
                res[d*4 +: 4] = s[3:0];
                c = 4'd0;
            end
        end
        if (c != 4'd0) res = 16'h9999;
        return res;
    endfunction

    always_comb begin
        pts = 4'd8;
        if (k_q == LW'(0))      pts = 4'd0;
        else if (k_q == LW'(1)) pts = 4'd1;
        else if (k_q == LW'(2)) pts = 4'd3;
        else if (k_q == LW'(3)) pts = 4'd5;
    end

    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        mask_d   = mask_q;
        kind_d   = kind_q;
        r_d      = r_q;
        k_d      = k_q;
        score_d  = score_q;
        lines_d  = lines_q;
        topout_d = topout_q;
        pop      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (place_valid) begin
                    mask_d  = place_mask;
                    kind_d  = place_kind;
                    state_d = S_MERGE;
                end
            end
            S_MERGE: begin
                for (int y = 0; y < ROWS; y++) begin
                    for (int x = 0; x < COLS; x++) begin
                        if (mask_q[y*COLS+x]) board_d[y][x*KW +: KW] = kind_q;
                    end
                end
                r_d     = '0;
                k_d     = '0;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                // A cleared row pulls the rows above down; r stays so the
                // row that dropped into place is tested next.
                if (row_full(board_q[r_q])) begin
                    for (int y = 0; y < ROWS-1; y++) begin
                        if (y >= 32'(r_q)) board_d[y] = board_q[y+1];
                    end
                    board_d[ROWS-1] = '0;
                    k_d = k_q + 1'b1;
                end else if (32'(r_q) == ROWS-1) begin
                    state_d = S_SCORE;
                end else begin
                    r_d = r_q + 1'b1;
                end
            end
            S_SCORE: begin
                lines_d = k_q;
                score_d = bcd_add(score_q, pts);
                state_d = (cnt_q != '0) ? S_GARB : S_DONE;
            end
            S_GARB: begin
                pop = 1'b1;
                if (board_q[ROWS-1] != '0) topout_d = 1'b1;
                for (int y = ROWS-1; y > 0; y--) begin
                    board_d[y] = board_q[y-1];
                end
                board_d[0] = garb_row(gq_mem_q[rd_ptr_q]);
                // Leave once this pop empties the queue; a push landing
                // on the last pop keeps one entry and one more cycle here.
                if (cnt_q == CNT_ONE && !gq_push) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (clear_board) begin
            state_d = S_IDLE;
            for (int y = 0; y < ROWS; y++) begin
                board_d[y] = '0;
            end
            score_d  = '0;
            lines_d  = '0;
            topout_d = 1'b0;
            pop      = 1'b0;
        end
    end

    always_comb begin
        push_ok = gq_push && (!gq_full || pop);
        cnt_d   = cnt_q;
        if (push_ok && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!push_ok && pop) cnt_d = cnt_q - 1'b1;
    end

    always_comb begin
        rd_kind_d = '0;
        if (32'(rd_x) < COLS && 32'(rd_y) < ROWS) begin
            rd_kind_d = board_q[rd_y][32'(rd_x)*KW +: KW];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            for (int y = 0; y < ROWS; y++) begin
                board_q[y] <= '0;
            end
            mask_q    <= '0;
            kind_q    <= '0;
            r_q       <= '0;
            k_q       <= '0;
            score_q   <= '0;
            lines_q   <= '0;
            topout_q  <= 1'b0;
            rd_kind_q <= '0;
        end else begin
            state_q   <= state_d;
            board_q   <= board_d;
            mask_q    <= mask_d;
            kind_q    <= kind_d;
            r_q       <= r_d;
            k_q       <= k_d;
            score_q   <= score_d;
            lines_q   <= lines_d;
            topout_q  <= topout_d;
            rd_kind_q <= rd_kind_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < GQ_DEPTH; i++) begin
                gq_mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clear_board) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                gq_mem_q[wr_ptr_q] <= gq_hole;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    assign ready      = (state_q == S_IDLE);
    assign busy       = ~ready;
    assign done       = (state_q == S_DONE);
    assign gq_full    = (cnt_q == CNT_FULL);
    assign gq_count   = cnt_q;
    assign rd_kind    = rd_kind_q;
    assign lines_last = lines_q;
    assign score      = score_q;
    assign topout     = topout_q;

endmodule

// File: tb/tb_playfield_engine.sv
// tb_playfield_engine: directed and randomized commits against an
// array/queue reference model of the playfield rules.
module tb_playfield_engine;

    localparam int COLS = 10;
    localparam int ROWS = 20;
    localparam int KW   = 3;
    localparam int GQD  = 8;
    localparam int NC   = ROWS*COLS;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          place_valid = 1'b0;
    logic [NC-1:0] place_mask = '0;
    logic [KW-1:0] place_kind = '0;
    logic          ready, done, busy;
    logic          gq_push = 1'b0;
    logic [3:0]    gq_hole = '0;
    logic          gq_full;
    logic [3:0]    gq_count;
    logic          clear_board = 1'b0;
    logic [3:0]    rd_x = '0;
    logic [4:0]    rd_y = '0;
    logic [KW-1:0] rd_kind;
    logic [4:0]    lines_last;
    logic [15:0]   score;
    logic          topout;

    int vectors = 0;
    int miscompares = 0;

    int mb [ROWS][COLS];
    int mq [$];
    int ms;
    bit mtop;

    always #5 clk = ~clk;

    playfield_engine #(
        .COLS(COLS), .ROWS(ROWS), .KW(KW),
        .GQ_DEPTH(GQD), .GARB_KIND(7)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .place_valid(place_valid), .place_mask(place_mask),
        .place_kind(place_kind),
        .ready(ready), .done(done), .busy(busy),
        .gq_push(gq_push), .gq_hole(gq_hole),
        .gq_full(gq_full), .gq_count(gq_count),
        .clear_board(clear_board),
        .rd_x(rd_x), .rd_y(rd_y), .rd_kind(rd_kind),
        .lines_last(lines_last), .score(score), .topout(topout)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v/1000%10), 4'(v/100%10), 4'(v/10%10), 4'(v%10)};
    endfunction

    task automatic model_reset();
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) mb[y][x] = 0;
        mq.delete();
        ms = 0;
        mtop = 1'b0;
    endtask

    // Merge, drop every full row keeping the rest in order, score, then
    // lift in each queued garbage row.
    task automatic model_commit(input logic [NC-1:0] m, input int kd,
                                output int k, output int g);
        int tmp [ROWS][COLS];
        int dst, h;
        bit full;
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                if (m[y*COLS+x]) mb[y][x] = kd;
        dst = 0;
        k = 0;
        for (int y = 0; y < ROWS; y++) begin
            full = 1'b1;
            for (int x = 0; x < COLS; x++) if (mb[y][x] == 0) full = 1'b0;
            if (full) k++;
            else begin
                for (int x = 0; x < COLS; x++) tmp[dst][x] = mb[y][x];
                dst++;
            end
        end
        for (int y = dst; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) tmp[y][x] = 0;
        mb = tmp;
        ms += (k == 0) ? 0 : (k == 1) ? 1 : (k == 2) ? 3 : (k == 3) ? 5 : 8;
        if (ms > 9999) ms = 9999;
        g = mq.size();
        while (mq.size() > 0) begin
            h = mq.pop_front();
            for (int x = 0; x < COLS; x++) if (mb[ROWS-1][x] != 0) mtop = 1'b1;
            for (int y = ROWS-1; y > 0; y--) mb[y] = mb[y-1];
            for (int x = 0; x < COLS; x++) mb[0][x] = (x == h) ? 0 : 7;
        end
    endtask

    task automatic push_one(input int h);
        gq_push = 1'b1;
        gq_hole = 4'(h);
        tick();
        gq_push = 1'b0;
        if (mq.size() < GQD) mq.push_back(h);
    endtask

    task automatic clear_all();
        clear_board = 1'b1;
        tick();
        clear_board = 1'b0;
        model_reset();
    endtask

    task automatic read_cell(input int x, input int y, output int v);
        rd_x = 4'(x);
        rd_y = 5'(y);
        tick();
        v = int'(rd_kind);
    endtask

    task automatic readback(input string p);
        int v;
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) begin
                read_cell(x, y, v);
                check($sformatf("%s(%0d,%0d)", p, x, y), v, mb[y][x]);
            end
        read_cell(12, 3, v);
        check({p, "_oob_x"}, v, 0);
        read_cell(2, 22, v);
        check({p, "_oob_y"}, v, 0);
    endtask

    task automatic commit(input logic [NC-1:0] m, input logic [KW-1:0] kd,
                          input bit noise, output int lat);
        int k, g, n;
        bit seen;
        check("ready", ready, 1);
        place_mask  = m;
        place_kind  = kd;
        place_valid = 1'b1;
        tick();
        place_valid = 1'b0;
        place_mask  = '0;
        n = 1;
        check("busy", busy, 1);
        model_commit(m, int'(kd), k, g);
        seen = 1'b0;
        while (!seen && n < 400) begin
            if (noise && n == 5) begin
                place_valid = 1'b1;
                place_mask  = '1;
                place_kind  = 3'd7;
            end
            tick();
            n++;
            place_valid = 1'b0;
            place_mask  = '0;
            if (done) seen = 1'b1;
        end
        lat = n;
        check("done_seen", seen, 1);
        check("latency", n, 3+ROWS+k+g);
        check("lines_last", lines_last, k);
        check("score", score, to_bcd(ms));
        check("topout", topout, mtop);
        check("gq_count", gq_count, mq.size());
        tick();
        check("ready_after", ready, 1);
    endtask

    task automatic rand_mask(output logic [NC-1:0] m);
        int mode, r;
        m = '0;
        mode = $urandom_range(0, 3);
        if (mode < 2) begin
            r = $urandom_range(0, 5);
            for (int x = 0; x < COLS; x++) if (mb[r][x] == 0) m[r*COLS+x] = 1'b1;
            if (mode == 0)
                for (int x = 0; x < COLS; x++)
                    if (mb[r+1][x] == 0) m[(r+1)*COLS+x] = 1'b1;
        end else begin
            repeat ($urandom_range(1, 8))
                m[$urandom_range(0, ROWS-1)*COLS + $urandom_range(0, COLS-1)] = 1'b1;
        end
    endtask

    initial begin
        logic [NC-1:0] m;
        int lat, v, np;
        bit sawdone;

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_score", score, 16'h0000);
        check("rst_gq_count", gq_count, 0);
        check("rst_gq_full", gq_full, 0);
        check("rst_topout", topout, 0);
        check("rst_lines", lines_last, 0);
        readback("rst");

        // single line clear
        m = '0;
        for (int x = 0; x < 9; x++) m[x] = 1'b1;
        commit(m, 3'd2, 1'b0, lat);
        m = '0;
        m[9] = 1'b1;
        commit(m, 3'd4, 1'b1, lat);
        check("s1_lat", lat, 24);
        check("s1_lines", lines_last, 1);
        check("s1_score", score, 16'h0001);
        read_cell(9, 0, v);
        check("s1_cell90", v, 0);
        readback("s1");

        // four lines in one pass
        clear_all();
        m = '0;
        for (int y = 0; y < 4; y++)
            for (int x = 1; x < COLS; x++) m[y*COLS+x] = 1'b1;
        commit(m, 3'd3, 1'b0, lat);
        m = '0;
        m[4*COLS+2] = 1'b1;
        commit(m, 3'd6, 1'b0, lat);
        m = '0;
        for (int y = 0; y < 4; y++) m[y*COLS] = 1'b1;
        commit(m, 3'd5, 1'b1, lat);
        check("s2_lines", lines_last, 4);
        check("s2_score", score, 16'h0008);
        read_cell(2, 0, v);
        check("s2_cell20", v, 6);
        readback("s2");

        // two garbage rows
        clear_all();
        push_one(3);
        push_one(7);
        check("s3_count2", gq_count, 2);
        m = '0;
        m[5*COLS] = 1'b1;
        commit(m, 3'd1, 1'b0, lat);
        check("s3_lat", lat, 25);
        check("s3_count0", gq_count, 0);
        read_cell(0, 7, v);
        check("s3_cell07", v, 1);
        read_cell(7, 0, v);
        check("s3_hole0", v, 0);
        read_cell(3, 1, v);
        check("s3_hole1", v, 0);
        read_cell(0, 0, v);
        check("s3_garb", v, 7);
        readback("s3");

        // top-out
        clear_all();
        m = '0;
        m[19*COLS+4] = 1'b1;
        commit(m, 3'd3, 1'b0, lat);
        check("s4_top_pre", topout, 0);
        push_one(0);
        m = '0;
        m[0] = 1'b1;
        commit(m, 3'd1, 1'b0, lat);
        check("s4_topout", topout, 1);
        read_cell(4, 19, v);
        check("s4_lost", v, 0);
        readback("s4");

        // FIFO overflow, then abort in SCAN
        m = '0;
        for (int x = 0; x < COLS; x++) if (mb[0][x] == 0) m[x] = 1'b1;
        commit(m, 3'd2, 1'b0, lat);
        check("s5_score_pre", score, 16'h0001);
        for (int i = 0; i < 9; i++) push_one(i);
        check("s5_full", gq_full, 1);
        check("s5_count", gq_count, 8);
        check("s5_model_q", mq.size(), 8);
        m = '0;
        m[5*COLS+5] = 1'b1;
        place_mask  = m;
        place_kind  = 3'd3;
        place_valid = 1'b1;
        tick();
        place_valid = 1'b0;
        tick();
        check("s5_busy", busy, 1);
        clear_board = 1'b1;
        tick();
        clear_board = 1'b0;
        model_reset();
        check("s5_ready", ready, 1);
        check("s5_score", score, 16'h0000);
        check("s5_count0", gq_count, 0);
        check("s5_full0", gq_full, 0);
        check("s5_topout", topout, 0);
        check("s5_lines", lines_last, 0);
        sawdone = 1'b0;
        repeat (40) begin
            if (done) sawdone = 1'b1;
            tick();
        end
        check("s5_nodone", sawdone, 0);
        readback("s5");

        // randomized commits
        for (int it = 0; it < 30; it++) begin
            np = ($urandom_range(0, 9) == 0) ? 10 : $urandom_range(0, 2);
            repeat (np) push_one($urandom_range(0, 15));
            check("rnd_qcount", gq_count, mq.size());
            check("rnd_qfull", gq_full, mq.size() == GQD);
            rand_mask(m);
            commit(m, 3'($urandom_range(0, 7)), 1'b1, lat);
            readback("rnd");
            if (it == 15) clear_all();
        end

        // score saturation
        clear_all();
        m = '0;
        for (int i = 0; i < 4*COLS; i++) m[i] = 1'b1;
        for (int i = 0; i < 1252; i++) commit(m, 3'd1, 1'b0, lat);
        check("sat_score", score, 16'h9999);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
